// File: rtl/bram_delay_ctrl_if.sv
// Stream-in / stream-out handshake plus single-port RAM bus for bram_delay_ctrl.
// The delay block sits on the slave side; the surrounding system and the RAM sit on the master side.
interface bram_delay_ctrl_if #(
  parameter int DATA_WIDTH = 16,
  parameter int ADDR_WIDTH = 6
);
  logic                  in_valid;
  logic                  in_ready;
  logic [DATA_WIDTH-1:0] in_sample;
  logic [ADDR_WIDTH-1:0] delay;
  logic                  out_valid;
  logic                  out_ready;
  logic [DATA_WIDTH-1:0] out_data;
  logic                  ram_en;
  logic                  ram_we;
  logic [ADDR_WIDTH-1:0] ram_addr;
  logic [DATA_WIDTH-1:0] ram_din;
  logic [DATA_WIDTH-1:0] ram_dout;

  modport slave (
    input  in_valid, in_sample, delay, out_ready, ram_dout,
    output in_ready, out_valid, out_data, ram_en, ram_we, ram_addr, ram_din
  );

  modport master (
    output in_valid, in_sample, delay, out_ready, ram_dout,
    input  in_ready, out_valid, out_data, ram_en, ram_we, ram_addr, ram_din
  );
endinterface

// File: rtl/bram_delay_ctrl.sv
// Programmable sample delay line over an external single-port RAM used as a circular buffer.
// One sample per transaction: read the delayed tap, capture it, write the new sample, present it.
module bram_delay_ctrl #(
  parameter int DATA_WIDTH = 16,
  parameter int ADDR_WIDTH = 6
) (
  input logic               clock,
  input logic               reset,
  bram_delay_ctrl_if.slave  bus
);

  typedef enum logic [2:0] {
    IDLE = 3'd0,
    RD   = 3'd1,
    CAP  = 3'd2,
    WR   = 3'd3,
    OUT  = 3'd4
  } state_t;

  localparam logic [ADDR_WIDTH-1:0] ADDR_ONE = ADDR_WIDTH'(1);
  localparam logic [ADDR_WIDTH-1:0] FILL_MAX = {ADDR_WIDTH{1'b1}};

  state_t                state_q, state_d;
  logic [ADDR_WIDTH-1:0] wr_ptr_q, wr_ptr_d;
  logic [ADDR_WIDTH-1:0] fill_cnt_q, fill_cnt_d;
  logic [DATA_WIDTH-1:0] out_data_q, out_data_d;
  logic [DATA_WIDTH-1:0] sample_q, sample_d;
  logic [ADDR_WIDTH-1:0] delay_q, delay_d;

  logic                  in_ready;
  logic                  out_valid;
  logic                  ram_en;
  logic                  ram_we;
  logic [ADDR_WIDTH-1:0] ram_addr;
  logic [DATA_WIDTH-1:0] ram_din;

  always_comb begin
    state_d    = state_q;
    wr_ptr_d   = wr_ptr_q;
    fill_cnt_d = fill_cnt_q;
    out_data_d = out_data_q;
    sample_d   = sample_q;
    delay_d    = delay_q;
    in_ready   = 1'b0;
    out_valid  = 1'b0;
    ram_en     = 1'b0;
    ram_we     = 1'b0;
    ram_addr   = wr_ptr_q;
    ram_din    = sample_q;

    unique case (state_q)
      IDLE: begin
        in_ready = 1'b1;
        if (bus.in_valid) begin
          sample_d = bus.in_sample;
          delay_d  = bus.delay;
          state_d  = RD;
        end
      end
      RD: begin
        // Read address wraps naturally in ADDR_WIDTH bits when delay exceeds the pointer.
        ram_en   = 1'b1;
        ram_addr = wr_ptr_q - delay_q;
        state_d  = CAP;
      end
      CAP: begin
        // Until the buffer holds delay_q samples the tap points at unwritten (or stale) RAM.
        if (delay_q == '0) begin
          out_data_d = sample_q;
        end else if (fill_cnt_q >= delay_q) begin
          out_data_d = bus.ram_dout;
        end else begin
          out_data_d = '0;
        end
        state_d = WR;
      end
      WR: begin
        ram_en   = 1'b1;
        ram_we   = 1'b1;
        wr_ptr_d = wr_ptr_q + ADDR_ONE;
        if (fill_cnt_q != FILL_MAX) begin
          fill_cnt_d = fill_cnt_q + ADDR_ONE;
        end
        state_d = OUT;
      end
      OUT: begin
        out_valid = 1'b1;
        if (bus.out_ready) begin
          state_d = IDLE;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q    <= IDLE;
      wr_ptr_q   <= '0;
      fill_cnt_q <= '0;
      out_data_q <= '0;
    end else begin
      state_q    <= state_d;
      wr_ptr_q   <= wr_ptr_d;
      fill_cnt_q <= fill_cnt_d;
      out_data_q <= out_data_d;
    end
  end

  // Latched transaction operands only matter after an accept, so they carry no reset.
  always_ff @(posedge clock) begin
    sample_q <= sample_d;
    delay_q  <= delay_d;
  end

  assign bus.in_ready  = in_ready;
  assign bus.out_valid = out_valid;
  assign bus.out_data  = out_data_q;
  assign bus.ram_en    = ram_en;
  assign bus.ram_we    = ram_we;
  assign bus.ram_addr  = ram_addr;
  assign bus.ram_din   = ram_din;

endmodule

// File: tb/tb_bram_delay_ctrl.sv
// Scoreboard bench for bram_delay_ctrl: directed sample sequences drive a queue of expected
// outputs and RAM accesses; an independent negedge monitor checks what the DUT presents.
module tb_bram_delay_ctrl;
  localparam int DW = 16;
  localparam int AW = 6;

  logic clock;
  logic reset;

  bram_delay_ctrl_if #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) bus ();

  bram_delay_ctrl #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  logic [DW-1:0] mem [0:(1<<AW)-1];
  always @(posedge clock) begin
    if (bus.ram_en) begin
      if (bus.ram_we) mem[bus.ram_addr] <= bus.ram_din;
      else            bus.ram_dout      <= mem[bus.ram_addr];
    end
  end

  int errors = 0;
  int checks = 0;
  int cyc = 0;
  int last_acc = -100;
  bit ov_prev = 1'b0;
  logic [AW-1:0] wp = '0;

  logic [DW-1:0] exp_q[$];
  logic [AW-1:0] rd_q[$];
  logic [AW-1:0] wr_q[$];
  logic [DW-1:0] din_q[$];

  task automatic chk(input string nm, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  task automatic clear_q();
    exp_q.delete(); rd_q.delete(); wr_q.delete(); din_q.delete();
    wp = '0;
  endtask

  always @(posedge clock) begin
    if (!reset && bus.in_valid && bus.in_ready) last_acc = cyc;
    cyc = cyc + 1;
  end

  always @(negedge clock) begin
    if (reset) begin
      ov_prev = 1'b0;
    end else begin
      if (bus.ram_en) begin
        if (bus.ram_we) begin
          chk("wr_timing", cyc - last_acc, 3);
          if (wr_q.size() == 0) chk("wr_unexpected", 1, 0);
          else begin
            chk("wr_addr", bus.ram_addr, wr_q.pop_front());
            chk("wr_din", bus.ram_din, din_q.pop_front());
          end
        end else begin
          chk("rd_timing", cyc - last_acc, 1);
          if (rd_q.size() == 0) chk("rd_unexpected", 1, 0);
          else chk("rd_addr", bus.ram_addr, rd_q.pop_front());
        end
      end
      if (bus.out_valid && !ov_prev) chk("ov_latency", cyc - last_acc, 4);
      if (bus.out_valid && bus.out_ready) begin
        if (exp_q.size() == 0) chk("out_unexpected", 1, 0);
        else chk("out_data", bus.out_data, exp_q.pop_front());
      end
      ov_prev = bus.out_valid;
    end
  end

  task automatic send(input logic [DW-1:0] s, input logic [AW-1:0] d,
                      input logic [DW-1:0] e, input bit push);
    int n = 0;
    while (!bus.in_ready && n < 200) begin
      @(posedge clock); #1;
      n++;
    end
    if (!bus.in_ready) begin
      chk("send_timeout", bus.in_ready, 1);
      return;
    end
    bus.in_valid  = 1'b1;
    bus.in_sample = s;
    bus.delay     = d;
    if (push) exp_q.push_back(e);
    rd_q.push_back(wp - d);
    wr_q.push_back(wp);
    din_q.push_back(s);
    wp = wp + 1'b1;
    @(posedge clock); #1;
    bus.in_valid  = 1'b0;
    bus.delay     = ~d;
    bus.in_sample = 16'hFFFF;
  endtask

  task automatic drain();
    int n = 0;
    while (exp_q.size() != 0 && n < 200) begin
      @(posedge clock); #1;
      n++;
    end
    chk("drain", exp_q.size(), 0);
    repeat (2) @(posedge clock);
    #1;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    clear_q();
    repeat (2) @(posedge clock);
    #1;
    reset = 1'b0;
  endtask

  initial begin
    #300000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  logic [DW-1:0] basic_exp [6] = '{16'd0, 16'd0, 16'd0, 16'd1, 16'd2, 16'd3};
  logic [DW-1:0] held;

  initial begin
    reset         = 1'b1;
    bus.in_valid  = 1'b0;
    bus.in_sample = '0;
    bus.delay     = '0;
    bus.out_ready = 1'b1;
    bus.ram_dout  = '0;
    for (int i = 0; i < (1<<AW); i++) mem[i] = '0;

    do_reset();
    chk("rst_in_ready", bus.in_ready, 1);
    chk("rst_out_valid", bus.out_valid, 0);
    chk("rst_out_data", bus.out_data, 0);
    chk("rst_ram_en", bus.ram_en, 0);
    chk("rst_ram_we", bus.ram_we, 0);

    // Basic delay of 3
    for (int i = 0; i < 6; i++) send(DW'(i + 1), 6'd3, basic_exp[i], 1'b1);
    drain();

    // Bypass
    send(16'h1234, 6'd0, 16'h1234, 1'b1);
    send(16'hABCD, 6'd0, 16'hABCD, 1'b1);
    drain();

    // Backpressure: hold OUT for 10 cycles with stray in_valid pulses
    bus.out_ready = 1'b0;
    send(16'h0055, 6'd0, 16'h0055, 1'b1);
    for (int n = 0; n < 20 && !bus.out_valid; n++) begin
      @(posedge clock); #1;
    end
    chk("bp_reach_out", bus.out_valid, 1);
    held = bus.out_data;
    for (int i = 0; i < 10; i++) begin
      bus.in_valid  = i[0];
      bus.in_sample = 16'hDEAD;
      bus.delay     = 6'd5;
      chk("bp_out_valid", bus.out_valid, 1);
      chk("bp_out_data", bus.out_data, 16'h0055);
      chk("bp_held", bus.out_data, held);
      chk("bp_in_ready", bus.in_ready, 0);
      @(posedge clock); #1;
    end
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b1;
    drain();

    // Reset in WR after 5 samples at delay 2
    do_reset();
    send(16'd11, 6'd2, 16'd0, 1'b1);
    send(16'd12, 6'd2, 16'd0, 1'b1);
    send(16'd13, 6'd2, 16'd11, 1'b1);
    send(16'd14, 6'd2, 16'd12, 1'b1);
    send(16'd15, 6'd2, 16'd13, 1'b1);
    send(16'd16, 6'd2, 16'd0, 1'b0);
    @(posedge clock); #1;
    @(posedge clock); #1;
    chk("abort_in_wr", bus.ram_we, 1);
    reset = 1'b1;
    clear_q();
    @(posedge clock); #1;
    reset = 1'b0;
    for (int i = 0; i < 3; i++) begin
      chk("post_rst_ram_en", bus.ram_en, 0);
      chk("post_rst_out_valid", bus.out_valid, 0);
      chk("post_rst_in_ready", bus.in_ready, 1);
      @(posedge clock); #1;
    end
    send(16'h0101, 6'd2, 16'h0000, 1'b1);
    send(16'h0202, 6'd2, 16'h0000, 1'b1);
    send(16'h0303, 6'd2, 16'h0101, 1'b1);
    drain();

    // Wrap at maximum delay
    do_reset();
    for (int k = 0; k < 130; k++) send(DW'(k), 6'd63, (k < 63) ? DW'(0) : DW'(k - 63), 1'b1);
    drain();

    chk("rd_q_empty", rd_q.size(), 0);
    chk("wr_q_empty", wr_q.size(), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
